// File: rtl/dffram_arb_pkg.sv
// Shared types for the two-port DFFRAM arbiter: FSM state encoding and the
// captured request record.
package dffram_arb_pkg;

  localparam int ARB_AWIDTH = 9;
  localparam int ARB_WSIZE  = 4;
  localparam int ARB_DWIDTH = 8 * ARB_WSIZE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RD   = 2'd2
  } arb_state_t;

  // The record widths follow the package defaults.
  // Instances overriding AWIDTH/WSIZE need a matching record.
  typedef struct packed {
    logic                  owner;
    logic [ARB_WSIZE-1:0]  we;
    logic [ARB_AWIDTH-1:0] a;
    logic [ARB_DWIDTH-1:0] di;
  } arb_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant.
// The priority pointer moves to the other requester on each handshake.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       hs,
  output logic [1:0] gnt
);

  logic prio_q;  // 1 = requester 1 wins a tie
  logic prio_d;

  always_comb begin
    gnt    = 2'b00;
    prio_d = prio_q;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
    if (hs) prio_d = gnt[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_q <= 1'b0;
    else        prio_q <= prio_d;
  end

endmodule

// File: rtl/dffram_arb2.sv
// Two-requester arbiter/sequencer for one DFFRAM512x32 macro.
// Each access drives EN0 for exactly one cycle, and read data is steered back to its issuer.
module dffram_arb2
  import dffram_arb_pkg::*;
#(
  parameter int AWIDTH = ARB_AWIDTH,
  parameter int WSIZE  = ARB_WSIZE
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 REQ0_VALID,
  output logic                 REQ0_READY,
  input  logic [WSIZE-1:0]     REQ0_WE,
  input  logic [AWIDTH-1:0]    REQ0_A,
  input  logic [8*WSIZE-1:0]   REQ0_DI,
  input  logic                 REQ1_VALID,
  output logic                 REQ1_READY,
  input  logic [WSIZE-1:0]     REQ1_WE,
  input  logic [AWIDTH-1:0]    REQ1_A,
  input  logic [8*WSIZE-1:0]   REQ1_DI,
  output logic                 RSP0_VALID,
  output logic [8*WSIZE-1:0]   RSP0_DO,
  output logic                 RSP1_VALID,
  output logic [8*WSIZE-1:0]   RSP1_DO,
  output logic                 RAM_EN0,
  output logic [WSIZE-1:0]     RAM_WE0,
  output logic [AWIDTH-1:0]    RAM_A0,
  output logic [8*WSIZE-1:0]   RAM_DI0,
  input  logic [8*WSIZE-1:0]   RAM_DO0,
  output logic                 BUSY
);

  arb_state_t         state_q, state_d;
  arb_req_t           req_q, req_d;
  logic               ram_en_q, ram_en_d;
  logic [WSIZE-1:0]   ram_we_q, ram_we_d;
  logic [1:0]         rsp_valid_q, rsp_valid_d;
  logic [8*WSIZE-1:0] rsp_do0_q, rsp_do0_d;
  logic [8*WSIZE-1:0] rsp_do1_q, rsp_do1_d;
  logic               busy_q, busy_d;

  logic [1:0] arb_req;
  logic [1:0] gnt;
  logic       hs;

  assign arb_req = (state_q == IDLE) ? {REQ1_VALID, REQ0_VALID} : 2'b00;
  assign hs      = |gnt;

  rr_arb2 u_rr_arb2 (
    .clk   (CLK),
    .rst_n (RST_N),
    .req   (arb_req),
    .hs    (hs),
    .gnt   (gnt)
  );

  // READY is gated by reset so that every output reads 0 while reset is held.
  assign REQ0_READY = gnt[0] & RST_N;
  assign REQ1_READY = gnt[1] & RST_N;

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    ram_en_d    = 1'b0;
    ram_we_d    = '0;
    rsp_valid_d = 2'b00;
    rsp_do0_d   = rsp_do0_q;
    rsp_do1_d   = rsp_do1_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          state_d  = ACC;
          req_d    = gnt[1] ? {1'b1, REQ1_WE, REQ1_A, REQ1_DI}
                            : {1'b0, REQ0_WE, REQ0_A, REQ0_DI};
          ram_en_d = 1'b1;
          ram_we_d = gnt[1] ? REQ1_WE : REQ0_WE;
        end
      end
      ACC: begin
        if (req_q.we == '0) begin
          state_d = RD;
        end else begin
          state_d                   = IDLE;
          rsp_valid_d[req_q.owner]  = 1'b1;
        end
      end
      RD: begin
        state_d                  = IDLE;
        rsp_valid_d[req_q.owner] = 1'b1;
        if (req_q.owner) rsp_do1_d = RAM_DO0;
        else             rsp_do0_d = RAM_DO0;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      req_q       <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= '0;
      rsp_valid_q <= 2'b00;
      rsp_do0_q   <= '0;
      rsp_do1_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_do0_q   <= rsp_do0_d;
      rsp_do1_q   <= rsp_do1_d;
      busy_q      <= busy_d;
    end
  end

  // Address and data come straight from the request record.
  // They only change on a new handshake, so the macro pins stay quiet between accesses.
  assign RAM_EN0    = ram_en_q;
  assign RAM_WE0    = ram_we_q;
  assign RAM_A0     = req_q.a;
  assign RAM_DI0    = req_q.di;
  assign RSP0_VALID = rsp_valid_q[0];
  assign RSP1_VALID = rsp_valid_q[1];
  assign RSP0_DO    = rsp_do0_q;
  assign RSP1_DO    = rsp_do1_q;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_dffram_arb2.sv
// Self-checking bench for dffram_arb2 with a behavioural DFFRAM512x32 behind the RAM pins.
module tb_dffram_arb2;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        REQ0_VALID = 1'b0, REQ1_VALID = 1'b0;
  logic        REQ0_READY, REQ1_READY;
  logic [3:0]  REQ0_WE = '0, REQ1_WE = '0;
  logic [8:0]  REQ0_A = '0, REQ1_A = '0;
  logic [31:0] REQ0_DI = '0, REQ1_DI = '0;
  logic        RSP0_VALID, RSP1_VALID;
  logic [31:0] RSP0_DO, RSP1_DO;
  logic        RAM_EN0;
  logic [3:0]  RAM_WE0;
  logic [8:0]  RAM_A0;
  logic [31:0] RAM_DI0;
  logic [31:0] RAM_DO0 = '0;
  logic        BUSY;

  int checks = 0;
  int errors = 0;
  int hs_seen = 0;
  int en_cnt = 0;
  int we_err = 0;
  int excl_err = 0;
  logic [31:0] last_do [2];
  logic [31:0] mem [512];

  always #5 CLK = ~CLK;

  dffram_arb2 dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_WE(REQ0_WE),
    .REQ0_A(REQ0_A), .REQ0_DI(REQ0_DI),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_WE(REQ1_WE),
    .REQ1_A(REQ1_A), .REQ1_DI(REQ1_DI),
    .RSP0_VALID(RSP0_VALID), .RSP0_DO(RSP0_DO),
    .RSP1_VALID(RSP1_VALID), .RSP1_DO(RSP1_DO),
    .RAM_EN0(RAM_EN0), .RAM_WE0(RAM_WE0), .RAM_A0(RAM_A0), .RAM_DI0(RAM_DI0),
    .RAM_DO0(RAM_DO0), .BUSY(BUSY)
  );

  // Macro model: synchronous, byte-masked write, registered read data.
  initial for (int i = 0; i < 512; i++) mem[i] = '0;
  always @(posedge CLK) begin
    if (RAM_EN0) begin
      for (int b = 0; b < 4; b++)
        if (RAM_WE0[b]) mem[RAM_A0][8*b +: 8] <= RAM_DI0[8*b +: 8];
      RAM_DO0 <= mem[RAM_A0];
    end
  end

  always @(negedge CLK) begin
    if (RST_N) begin
      if ((REQ0_VALID && REQ0_READY) || (REQ1_VALID && REQ1_READY)) hs_seen++;
      if (RAM_EN0) en_cnt++;
      if (!RAM_EN0 && RAM_WE0 != 4'b0) we_err++;
      if (REQ0_READY && REQ1_READY) excl_err++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return {REQ0_READY, REQ1_READY, RSP0_VALID, RSP1_VALID, RSP0_DO, RSP1_DO,
            RAM_EN0, RAM_WE0, RAM_A0, RAM_DI0, BUSY};
  endfunction

  task automatic set_req(input int p, input logic v, input logic [3:0] we,
                         input logic [8:0] a, input logic [31:0] di);
    if (p == 0) begin
      REQ0_VALID = v; REQ0_WE = we; REQ0_A = a; REQ0_DI = di;
    end else begin
      REQ1_VALID = v; REQ1_WE = we; REQ1_A = a; REQ1_DI = di;
    end
  endtask

  function automatic logic rdy(input int p);
    return (p == 0) ? REQ0_READY : REQ1_READY;
  endfunction

  function automatic logic [31:0] rsp_do(input int p);
    return (p == 0) ? RSP0_DO : RSP1_DO;
  endfunction

  task automatic do_reset();
    RST_N = 1'b0;
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    last_do[0] = '0;
    last_do[1] = '0;
    @(posedge CLK); #1;
  endtask

  // Issue one request and follow it to completion. Entered and left at posedge+1.
  task automatic run_req(input int p, input logic [3:0] we, input logic [8:0] a,
                         input logic [31:0] di, input logic [31:0] exp);
    int cyc;
    logic [1:0] exp_rsp;
    exp_rsp = 2'b01 << p;
    set_req(p, 1'b1, we, a, di);
    #1;
    cyc = 0;
    while (!rdy(p) && cyc < 20) begin
      @(posedge CLK); #1; cyc++;
    end
    if (!rdy(p)) begin
      chk("ready_timeout", rdy(p), 1'b1);
      set_req(p, 1'b0, '0, '0, '0);
      return;
    end
    chk("ready_other_low", rdy(1 - p), 1'b0);
    @(posedge CLK); #1;
    set_req(p, 1'b0, '0, '0, '0);
    chk("acc_pins", {RAM_EN0, RAM_WE0, RAM_A0, RAM_DI0}, {1'b1, we, a, di});
    @(posedge CLK); #1;
    if (we != 4'b0) begin
      chk("wr_rsp_pulse", {RSP1_VALID, RSP0_VALID}, exp_rsp);
      chk("wr_do_held", rsp_do(p), last_do[p]);
      chk("wr_pins_idle", {RAM_EN0, RAM_WE0, RAM_A0, RAM_DI0}, {1'b0, 4'b0, a, di});
    end else begin
      chk("rd_no_early_rsp", {RSP1_VALID, RSP0_VALID, BUSY}, 3'b001);
      @(posedge CLK); #1;
      chk("rd_rsp_pulse", {RSP1_VALID, RSP0_VALID}, exp_rsp);
      chk("rd_data", rsp_do(p), exp);
      chk("rd_other_do_held", rsp_do(1 - p), last_do[1 - p]);
      last_do[p] = exp;
    end
  endtask

  typedef struct {
    int          port;
    logic [3:0]  we;
    logic [8:0]  a;
    logic [31:0] di;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int n [2];
    int r [2];
    int g, hp, cyc, k, last_hs, pulses;

    vecs[0] = '{0, 4'b1111, 9'h000, 32'hAA0055BB, 32'h0};
    vecs[1] = '{0, 4'b0000, 9'h000, 32'h0,        32'hAA0055BB};
    vecs[2] = '{0, 4'b1111, 9'h1F2, 32'hAA0055DD, 32'h0};
    vecs[3] = '{0, 4'b0001, 9'h1F2, 32'hAB000033, 32'h0};
    vecs[4] = '{0, 4'b0000, 9'h1F2, 32'h0,        32'hAA005533};
    vecs[5] = '{1, 4'b1111, 9'h0A5, 32'h12345678, 32'h0};
    vecs[6] = '{1, 4'b0000, 9'h0A5, 32'h0,        32'h12345678};
    vecs[7] = '{1, 4'b1010, 9'h0A5, 32'hFFFFFFFF, 32'h0};
    vecs[8] = '{0, 4'b0000, 9'h0A5, 32'h0,        32'hFF34FF78};

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_outputs", all_outs(), '0);
    @(negedge CLK);
    RST_N = 1'b1;
    last_do[0] = '0;
    last_do[1] = '0;
    @(posedge CLK); #1;
    chk("post_reset_idle", {BUSY, REQ0_READY, REQ1_READY}, 3'b000);
    REQ0_VALID = 1'b1;
    REQ1_VALID = 1'b1;
    #1;
    chk("reset_prio_0", {REQ1_READY, REQ0_READY}, 2'b01);
    REQ0_VALID = 1'b0;
    REQ1_VALID = 1'b0;
    @(posedge CLK); #1;

    for (int i = 0; i < 9; i++)
      run_req(vecs[i].port, vecs[i].we, vecs[i].a, vecs[i].di, vecs[i].exp);

    // Contention: both ports valid back to back, writes then reads.
    do_reset();
    for (int ph = 0; ph < 2; ph++) begin
      n[0] = 0; n[1] = 0; r[0] = 0; r[1] = 0; g = 0; cyc = 0;
      for (int p = 0; p < 2; p++)
        set_req(p, 1'b1, (ph == 0) ? 4'hF : 4'h0,
                (p == 0) ? 9'h010 : 9'h1F0, (p == 0) ? 32'h100 : 32'h11110000);
      #1;
      while ((r[0] < 4 || r[1] < 4) && cyc < 100) begin
        if (RSP0_VALID) begin
          if (ph == 1) chk("cont_rd0_data", RSP0_DO, 32'h100 + r[0]);
          r[0]++;
        end
        if (RSP1_VALID) begin
          if (ph == 1) chk("cont_rd1_data", RSP1_DO, 32'h11110000 + r[1]);
          r[1]++;
        end
        hp = -1;
        if (REQ0_READY) hp = 0;
        else if (REQ1_READY) hp = 1;
        if (hp >= 0) begin
          chk("cont_grant_order", hp, g % 2);
          g++;
        end
        @(posedge CLK); #1;
        cyc++;
        if (hp >= 0) begin
          n[hp]++;
          if (n[hp] < 4)
            set_req(hp, 1'b1, (ph == 0) ? 4'hF : 4'h0,
                    (hp == 0) ? 9'h010 + n[hp] : 9'h1F0 + n[hp],
                    (hp == 0) ? 32'h100 + n[hp] : 32'h11110000 + n[hp]);
          else
            set_req(hp, 1'b0, '0, '0, '0);
        end
      end
      chk("cont_rsp_counts", {r[0], r[1], g}, {32'd4, 32'd4, 32'd8});
    end
    last_do[0] = 32'h103;
    last_do[1] = 32'h11110003;

    // Single requester: REQ1 alone, five reads held back to back.
    k = 0; r[1] = 0; cyc = 0; last_hs = 0;
    set_req(1, 1'b1, 4'h0, 9'h1F0, '0);
    #1;
    while (r[1] < 5 && cyc < 60) begin
      if (RSP1_VALID) begin
        chk("single_rd_data", RSP1_DO, 32'h11110000 + (r[1] % 4));
        r[1]++;
      end
      hp = 0;
      if (REQ1_READY) begin
        if (k > 0) chk("single_gap", cyc - last_hs, 3);
        last_hs = cyc;
        hp = 1;
      end
      @(posedge CLK); #1;
      cyc++;
      if (hp == 1) begin
        k++;
        if (k < 5) set_req(1, 1'b1, 4'h0, 9'h1F0 + (k % 4), '0);
        else       set_req(1, 1'b0, '0, '0, '0);
      end
    end
    chk("single_rsp_count", r[1], 5);
    last_do[1] = 32'h11110000;

    // Reset landing in RD.
    set_req(0, 1'b1, 4'h0, 9'h000, '0);
    #1;
    cyc = 0;
    while (!REQ0_READY && cyc < 20) begin
      @(posedge CLK); #1; cyc++;
    end
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("midrd_in_rd", {BUSY, RSP0_VALID}, 2'b10);
    RST_N = 1'b0;
    #1;
    chk("midrd_outputs_zero", all_outs(), '0);
    set_req(0, 1'b0, '0, '0, '0);
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    last_do[0] = '0;
    last_do[1] = '0;
    pulses = 0;
    repeat (5) begin
      @(posedge CLK); #1;
      if (RSP0_VALID || RSP1_VALID) pulses++;
    end
    chk("midrd_no_rsp", pulses, 0);
    run_req(0, 4'h0, 9'h000, '0, 32'hAA0055BB);

    repeat (3) @(posedge CLK);
    #1;
    chk("en_per_handshake", en_cnt, hs_seen);
    chk("we_only_with_en", we_err, 0);
    chk("ready_exclusive", excl_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
